// File: rtl/prewish5k_button_arbiter.sv
// rtl/prewish5k_button_arbiter.sv - round-robin arbiter forwarding debouncer status events to one consumer port
module prewish5k_button_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int CHW        = 3,
    parameter int ALIVE_BITS = 22
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [NUM_CH-1:0]     CH_STB_I,
    input  logic [8*NUM_CH-1:0]   CH_DAT_I,
    input  logic                  RDY_I,
    output logic                  STB_O,
    output logic [7:0]            DAT_O,
    output logic [CHW-1:0]        CHN_O,
    input  logic                  STB_I,
    input  logic [7:0]            DAT_I,
    output logic [NUM_CH-1:0]     OVR_O,
    output logic [NUM_CH-1:0]     EN_O,
    output logic                  o_alive
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CHW:0] NUM_CH_W = (CHW+1)'(NUM_CH);

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_CH-1:0]      pend;
    logic [NUM_CH-1:0]      en;
    logic [NUM_CH-1:0]      ovr;
    logic [NUM_CH-1:0]      req;
    logic [NUM_CH-1:0]      cap;
    logic [NUM_CH-1:0]      grant_vec;
    logic [NUM_CH-1:0]      pend_nxt;
    logic [NUM_CH-1:0]      ovr_nxt;
    logic [NUM_CH-1:0]      en_nxt;
    logic [NUM_CH-1:0]      cfg_mask;
    logic [2*NUM_CH-1:0]    req2;
    logic [7:0]             chan_buf [NUM_CH];
    logic [7:0]             win_dat;
    logic [CHW-1:0]         rr_ptr;
    logic [CHW-1:0]         winner;
    logic [CHW-1:0]         offset;
    logic [CHW:0]           sum;
    logic                   grant;
    logic                   cfg_en;
    logic                   cfg_clr;
    logic                   cfg_flush;
    logic [ALIVE_BITS-1:0]  alive_cnt;

    assign EN_O     = en;
    assign OVR_O    = ovr;
    assign STB_O    = (state == SEND);
    assign cfg_mask = DAT_I[NUM_CH-1:0];

    // Pick the first enabled pending channel at or after rr_ptr (rotate, then lowest set bit).
    always_comb begin
        req    = pend & en;
        req2   = {req, req} >> rr_ptr;
        offset = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req2[i]) begin
                offset = CHW'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= NUM_CH_W) begin
            sum = sum - NUM_CH_W;
        end
        winner    = sum[CHW-1:0];
        grant     = (state == IDLE) && RDY_I && (|req);
        win_dat   = '0;
        grant_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (winner == CHW'(k)) begin
                win_dat      = chan_buf[k];
                grant_vec[k] = grant;
            end
        end
    end

    // Next pending/enable/overrun values: grant clears, flush clears, capture sets, disable clears last.
    always_comb begin
        cap       = en & CH_STB_I;
        cfg_en    = STB_I && (DAT_I[7:6] == 2'b01);
        cfg_clr   = STB_I && (DAT_I[7:6] == 2'b10);
        cfg_flush = STB_I && (DAT_I[7:6] == 2'b11);

        pend_nxt = pend & ~grant_vec;
        if (cfg_flush) begin
            pend_nxt = '0;
        end
        pend_nxt = pend_nxt | cap;

        en_nxt = en;
        if (cfg_en) begin
            en_nxt   = cfg_mask;
            pend_nxt = pend_nxt & cfg_mask;
        end

        ovr_nxt = ovr;
        if (cfg_clr) begin
            ovr_nxt = ovr & ~cfg_mask;
        end
        // A recapture on the channel being granted replaces data already sent, so it is not an overrun.
        ovr_nxt = ovr_nxt | (cap & pend & ~grant_vec);
    end

    // Output sequencer: one strobe cycle followed by a mandatory gap cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SEND;
            SEND:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-channel event latches, enable mask and sticky overrun flags.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pend <= '0;
            en   <= '1;
            ovr  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                chan_buf[k] <= '0;
            end
        end else begin
            pend <= pend_nxt;
            en   <= en_nxt;
            ovr  <= ovr_nxt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (cap[k]) begin
                    chan_buf[k] <= CH_DAT_I[8*k +: 8];
                end
            end
        end
    end

    // Register the granted event and advance the round-robin pointer past the winner.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            DAT_O  <= '0;
            CHN_O  <= '0;
            rr_ptr <= '0;
        end else if (grant) begin
            DAT_O  <= win_dat;
            CHN_O  <= winner;
            rr_ptr <= (winner == CHW'(NUM_CH - 1)) ? '0 : winner + CHW'(1);
        end
    end

    // Free-running heartbeat: toggle on every counter wrap.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            alive_cnt <= '0;
            o_alive   <= 1'b0;
        end else begin
            alive_cnt <= alive_cnt + ALIVE_BITS'(1);
            if (&alive_cnt) begin
                o_alive <= ~o_alive;
            end
        end
    end

endmodule

// File: tb/tb_prewish5k_button_arbiter.sv
// tb/tb_prewish5k_button_arbiter.sv - scoreboard bench for prewish5k_button_arbiter
module tb_prewish5k_button_arbiter;

    localparam int N  = 4;
    localparam int AB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   ch_stb = '0;
    logic [8*N-1:0] ch_dat = '0;
    logic           rdy = 1'b0;
    logic           cfg_stb = 1'b0;
    logic [7:0]     cfg_dat = '0;
    logic           stb_o;
    logic [7:0]     dat_o;
    logic [2:0]     chn_o;
    logic [N-1:0]   ovr_o;
    logic [N-1:0]   en_o;
    logic           alive_o;

    prewish5k_button_arbiter #(.NUM_CH(N), .CHW(3), .ALIVE_BITS(AB)) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .CH_STB_I (ch_stb),
        .CH_DAT_I (ch_dat),
        .RDY_I    (rdy),
        .STB_O    (stb_o),
        .DAT_O    (dat_o),
        .CHN_O    (chn_o),
        .STB_I    (cfg_stb),
        .DAT_I    (cfg_dat),
        .OVR_O    (ovr_o),
        .EN_O     (en_o),
        .o_alive  (alive_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int chn;
        int dat;
    } ev_t;

    ev_t          exp_q[$];
    int           cyc = 0;
    int           cool = 0;
    int           rr = 0;
    int           n_alive = 0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_en = '1;
    logic [N-1:0] m_ovr = '0;
    logic [7:0]   m_buf [N];

    int   total = 0;
    int   bad = 0;
    int   rd_idx = 0;
    logic done = 1'b0;

    // Reference model: per edge, decide a grant from the rules, then apply config and captures.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  = '0;
            m_en    = '1;
            m_ovr   = '0;
            cool    = 0;
            rr      = 0;
            n_alive = 0;
            exp_q.delete();
        end else begin : model_step
            int           gw;
            logic [N-1:0] old_pend;
            logic [N-1:0] old_en;
            logic [N-1:0] mask;
            logic [1:0]   op;
            cyc      = cyc + 1;
            n_alive  = n_alive + 1;
            old_pend = m_pend;
            old_en   = m_en;
            gw       = -1;
            op       = cfg_stb ? cfg_dat[7:6] : 2'b00;
            mask     = cfg_dat[N-1:0];
            if (cool > 0) begin
                cool = cool - 1;
            end else if (rdy) begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (rr + i) % N;
                    if (gw < 0 && old_pend[c] && old_en[c]) gw = c;
                end
            end
            if (gw >= 0) begin
                exp_q.push_back('{cyc, gw, int'(m_buf[gw])});
                m_pend[gw] = 1'b0;
                rr   = (gw + 1) % N;
                cool = 2;
            end
            if (op == 2'b11) m_pend = '0;
            if (op == 2'b10) m_ovr = m_ovr & ~mask;
            for (int k = 0; k < N; k++) begin
                if (old_en[k] && ch_stb[k]) begin
                    if (old_pend[k] && gw != k) m_ovr[k] = 1'b1;
                    m_buf[k]  = ch_dat[8*k +: 8];
                    m_pend[k] = 1'b1;
                end
            end
            if (op == 2'b01) begin
                m_en   = mask;
                m_pend = m_pend & mask;
            end
        end
    end

    // Monitor: checks reset values, scoreboard events, flags and heartbeat away from the active edge.
    always begin
        @(negedge clk or posedge rst);
        if (rst) begin
            #1;
            rd_idx = 0;
            total++;
            if (stb_o !== 1'b0 || dat_o !== 8'h00 || chn_o !== 3'd0 || en_o !== 4'hF ||
                ovr_o !== 4'h0 || alive_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: got stb=%0b dat=%h chn=%0d en=%h ovr=%h alive=%0b, want stb=0 dat=00 chn=0 en=f ovr=0 alive=0",
                         stb_o, dat_o, chn_o, en_o, ovr_o, alive_o);
            end
        end else if (done) begin
            total++;
            if (rd_idx != exp_q.size()) begin
                bad++;
                $display("FAIL drain: got %0d events delivered, want %0d", rd_idx, exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else begin
            while (rd_idx < exp_q.size() && exp_q[rd_idx].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_stb: got no strobe at cycle %0d, want chn=%0d dat=%h",
                         exp_q[rd_idx].cyc, exp_q[rd_idx].chn, exp_q[rd_idx].dat);
                rd_idx++;
            end
            if (stb_o) begin
                total++;
                if (rd_idx < exp_q.size() && exp_q[rd_idx].cyc == cyc) begin
                    if (int'(chn_o) != exp_q[rd_idx].chn || int'(dat_o) != exp_q[rd_idx].dat) begin
                        bad++;
                        $display("FAIL event cycle %0d: got chn=%0d dat=%h, want chn=%0d dat=%h",
                                 cyc, chn_o, dat_o, exp_q[rd_idx].chn, exp_q[rd_idx].dat);
                    end
                    rd_idx++;
                end else begin
                    bad++;
                    $display("FAIL unexpected_stb cycle %0d: got chn=%0d dat=%h, want no strobe",
                             cyc, chn_o, dat_o);
                end
            end
            total++;
            if (en_o !== m_en) begin
                bad++;
                $display("FAIL en cycle %0d: got %h, want %h", cyc, en_o, m_en);
            end
            total++;
            if (ovr_o !== m_ovr) begin
                bad++;
                $display("FAIL ovr cycle %0d: got %h, want %h", cyc, ovr_o, m_ovr);
            end
            total++;
            if (alive_o !== 1'(n_alive >> AB)) begin
                bad++;
                $display("FAIL alive cycle %0d: got %0b, want %0b", cyc, alive_o, 1'(n_alive >> AB));
            end
        end
    end

    task automatic tick(input logic [N-1:0] s, input logic [8*N-1:0] d, input logic r,
                        input logic cs, input logic [7:0] cd);
        ch_stb  = s;
        ch_dat  = d;
        rdy     = r;
        cfg_stb = cs;
        cfg_dat = cd;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) tick('0, '0, r, 1'b0, 8'h00);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(3, 1'b1);

        // single event on channel 2
        tick(4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 8'h00);
        idle(6, 1'b1);

        // fairness: all channels at once, twice
        tick(4'hF, 32'h1312_1110, 1'b1, 1'b0, 8'h00);
        idle(14, 1'b1);
        tick(4'hF, 32'h2322_2120, 1'b1, 1'b0, 8'h00);
        idle(14, 1'b1);

        // back-pressure and overrun, then write-1-to-clear
        tick(4'b0010, 32'h0000_0100, 1'b0, 1'b0, 8'h00);
        idle(2, 1'b0);
        tick(4'b0010, 32'h0000_0200, 1'b0, 1'b0, 8'h00);
        idle(3, 1'b0);
        idle(6, 1'b1);
        tick('0, '0, 1'b1, 1'b1, 8'h82);
        idle(2, 1'b1);

        // enable mask and flush
        tick('0, '0, 1'b1, 1'b1, 8'h45);
        tick(4'b0010, 32'h0000_3300, 1'b1, 1'b0, 8'h00);
        idle(4, 1'b1);
        tick(4'b0001, 32'h0000_0044, 1'b0, 1'b0, 8'h00);
        idle(1, 1'b0);
        tick('0, '0, 1'b0, 1'b1, 8'hC0);
        idle(4, 1'b1);
        tick('0, '0, 1'b1, 1'b1, 8'h4F);
        idle(3, 1'b1);

        // same-cycle recapture on channel 3
        tick(4'b1000, 32'h3000_0000, 1'b1, 1'b0, 8'h00);
        tick(4'b1000, 32'h3100_0000, 1'b1, 1'b0, 8'h00);
        idle(8, 1'b1);

        // reset asserted while the strobe is high
        tick(4'b0001, 32'h0000_0077, 1'b1, 1'b0, 8'h00);
        tick('0, '0, 1'b1, 1'b0, 8'h00);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4, 1'b0);

        // randomized traffic with back-pressure and config writes
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0]   s;
            logic [8*N-1:0] d;
            logic           r;
            logic           cs;
            logic [7:0]     cd;
            s  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            d  = ($urandom);
            r  = ($urandom_range(0, 3) != 0);
            cs = ($urandom_range(0, 24) == 0);
            cd = 8'($urandom);
            if (i % 250 == 0) begin
                cs = 1'b1;
                cd = 8'h4F;
            end
            tick(s, d, r, cs, cd);
        end
        idle(12, 1'b1);

        done = 1'b1;
        repeat (4) @(negedge clk);
        $display("FAIL no_summary: got no summary line, want one");
        $fatal(1);
    end

endmodule
